frame_write_arbiter: RTL and testbench

- Owns the single write port of the frame buffer RAM, a 640x480 display packed two pixels per 16-bit word.
- Shares the port between three requesters: the red bike trail writer, the blue bike trail writer, and a built-in clear engine that wipes the whole buffer at round start.
- Converts pixel coordinates into packed word writes.
- Issues at most one registered write per cycle.

---
 rtl/frame_write_arbiter.sv | 156 +++++++++++++++
 tb/tb_frame_write_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_write_arbiter.sv
// frame_write_arbiter: owns the frame-buffer RAM write port (two 4-bit pixels
// per 16-bit word). It shares the port between the red and blue trail writers
// and a full-buffer clear engine, and issues at most one registered write per cycle.
// Build option: FIXED_PRIORITY_EN makes red always win ties. No pointer is kept.
module frame_write_arbiter #(
    parameter int          H_RES    = 640,
    parameter int          V_RES    = 480,
    parameter logic [3:0]  BG_COLOR = 4'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clear_start,
    output logic        clear_busy,
    output logic        clear_done,
    input  logic        r_req,
    input  logic [9:0]  r_x,
    input  logic [9:0]  r_y,
    input  logic [3:0]  r_color,
    output logic        r_ack,
    input  logic        b_req,
    input  logic [9:0]  b_x,
    input  logic [9:0]  b_y,
    input  logic [3:0]  b_color,
    output logic        b_ack,
    output logic        drop,
    output logic        WE,
    output logic [18:0] write_address,
    output logic [15:0] Data_Out
);

    localparam logic [18:0] HALF_W    = 19'(H_RES / 2);
    localparam logic [18:0] LAST_WORD = 19'((H_RES / 2) * V_RES - 1);
    localparam logic [10:0] X_LIM     = 11'(H_RES);
    localparam logic [10:0] Y_LIM     = 11'(V_RES);
    localparam logic [15:0] CLR_WORD  = {4'h0, BG_COLOR, 4'h0, BG_COLOR};

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [18:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        drop_q, drop_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        grant_r, grant_b, idle_free;
    logic [9:0]  sel_x, sel_y;
    logic [3:0]  sel_c;
    logic        in_range;

`ifndef FIXED_PRIORITY_EN
    typedef enum logic {SIDE_RED, SIDE_BLUE} side_t;
    side_t ptr_q, ptr_d;

    // Round-robin pointer register; it names the side preferred on a tie.
    always_ff @(posedge Clk) begin
        if (Reset) ptr_q <= SIDE_RED;
        else       ptr_q <= ptr_d;
    end
`endif

    // Grant decision: bikes are served only in IDLE, and never alongside clear_start.
    always_comb begin
        idle_free = (state_q == S_IDLE) && !clear_start;
`ifdef FIXED_PRIORITY_EN
        grant_r = idle_free && r_req;
        grant_b = idle_free && b_req && !r_req;
`else
        grant_r = idle_free && r_req && (!b_req || (ptr_q == SIDE_RED));
        grant_b = idle_free && b_req && !grant_r;
        ptr_d   = ptr_q;
        if (grant_r)      ptr_d = SIDE_BLUE;
        else if (grant_b) ptr_d = SIDE_RED;
`endif
    end

    // Select the granted request's coordinates and colour, then check them against the frame.
    always_comb begin
        sel_x    = grant_b ? b_x     : r_x;
        sel_y    = grant_b ? b_y     : r_y;
        sel_c    = grant_b ? b_color : r_color;
        in_range = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
    end

    // Next state, clear counter and next write-stage contents.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        drop_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (grant_r || grant_b) begin
                    if (in_range) begin
                        we_d   = 1'b1;
                        addr_d = 19'(sel_x[9:1]) + 19'(sel_y) * HALF_W;
                        data_d = {4'h0, sel_c, 4'h0, sel_c};
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                we_d   = 1'b1;
                addr_d = cnt_q;
                data_d = CLR_WORD;
                // A restart takes precedence over finishing, so an aborted pass never reaches DONE.
                if (clear_start)             cnt_d   = '0;
                else if (cnt_q == LAST_WORD) state_d = S_DONE;
                else                         cnt_d   = cnt_q + 19'd1;
            end
            S_DONE: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counter and registered write stage.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            drop_q  <= drop_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign r_ack         = grant_r;
    assign b_ack         = grant_b;
    assign clear_busy    = (state_q != S_IDLE);
    assign clear_done    = (state_q == S_DONE);
    assign WE            = we_q;
    assign drop          = drop_q;
    assign write_address = addr_q;
    assign Data_Out      = data_q;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Testbench for frame_write_arbiter. It uses a reduced V_RES to keep clears short
// and checks every cycle against a behavioural reference model.
module tb_frame_write_arbiter;

    localparam int         H_RES = 640;
    localparam int         V_RES = 60;
    localparam logic [3:0] BG    = 4'h0;
    localparam int         WORDS = (H_RES / 2) * V_RES;

    logic        Clk = 1'b0;
    logic        Reset, clear_start;
    logic        clear_busy, clear_done;
    logic        r_req, b_req, r_ack, b_ack, drop, WE;
    logic [9:0]  r_x, r_y, b_x, b_y;
    logic [3:0]  r_color, b_color;
    logic [18:0] write_address;
    logic [15:0] Data_Out;

    frame_write_arbiter #(.H_RES(H_RES), .V_RES(V_RES), .BG_COLOR(BG)) dut (
        .Clk(Clk), .Reset(Reset), .clear_start(clear_start),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .r_req(r_req), .r_x(r_x), .r_y(r_y), .r_color(r_color), .r_ack(r_ack),
        .b_req(b_req), .b_x(b_x), .b_y(b_y), .b_color(b_color), .b_ack(b_ack),
        .drop(drop), .WE(WE), .write_address(write_address), .Data_Out(Data_Out)
    );

    always #5 Clk = ~Clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: clear pass progress, tie preference, predicted write stage.
    bit          m_clr, m_done, m_pref_blue;
    int          m_idx;
    bit          p_we, p_drop, rst_prev;
    int          p_addr, p_data;
    bit          g_r, g_b;
    bit          obs_r, obs_b, obs_done;
    int          done_seen;

    // One clock cycle: inputs must already be driven at posedge+1.
    task automatic cyc();
        int         x, y;
        logic [3:0] c;
        logic [15:0] d;
        #1;
        g_r = 0; g_b = 0;
        if (!m_clr && !m_done && !clear_start) begin
            if (r_req && b_req) begin
`ifdef FIXED_PRIORITY_EN
                g_r = 1;
`else
                if (m_pref_blue) g_b = 1; else g_r = 1;
`endif
            end else begin
                g_r = r_req;
                g_b = b_req;
            end
        end
        obs_r    = (r_ack === 1'b1);
        obs_b    = (b_ack === 1'b1);
        obs_done = (clear_done === 1'b1);
        check("r_ack", r_ack, g_r);
        check("b_ack", b_ack, g_b);
        check("clear_busy", clear_busy, m_clr || m_done);
        check("clear_done", clear_done, m_done);
        if (obs_done) done_seen++;

        p_we = 0; p_drop = 0; rst_prev = Reset;
        if (Reset) begin
            m_clr = 0; m_done = 0; m_pref_blue = 0; p_addr = 0; p_data = 0;
        end else if (m_clr) begin
            p_we = 1; p_addr = m_idx; d = {4'h0, BG, 4'h0, BG}; p_data = d;
            if (clear_start)          m_idx = 0;
            else if (m_idx == WORDS-1) begin m_clr = 0; m_done = 1; end
            else                      m_idx++;
        end else if (clear_start) begin
            m_clr = 1; m_done = 0; m_idx = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (g_r || g_b) begin
            x = g_b ? int'(b_x) : int'(r_x);
            y = g_b ? int'(b_y) : int'(r_y);
            c = g_b ? b_color : r_color;
            if (x < H_RES && y < V_RES) begin
                p_we = 1; p_addr = x / 2 + y * (H_RES / 2);
                d = {4'h0, c, 4'h0, c}; p_data = d;
            end else begin
                p_drop = 1;
            end
            m_pref_blue = g_r;
        end

        @(posedge Clk);
        #1;
        check("WE", WE, p_we);
        check("drop", drop, p_drop);
        if (p_we || rst_prev) begin
            check("write_address", write_address, p_addr);
            check("Data_Out", Data_Out, p_data);
        end
    endtask

    initial begin
        logic [3:0] order;
        int nwe, back, i_done;

        Reset = 1; clear_start = 0;
        r_req = 0; r_x = 0; r_y = 0; r_color = 0;
        b_req = 0; b_x = 0; b_y = 0; b_color = 0;
        repeat (3) cyc();
        check("reset_WE", WE, 0);
        check("reset_busy", clear_busy, 0);
        Reset = 0;

        // Single red request
        r_req = 1; r_x = 10; r_y = 2; r_color = 4'h4;
        cyc();
        check("t1_ack", obs_r, 1);
        check("t1_we", WE, 1);
        check("t1_addr", write_address, 645);
        check("t1_data", Data_Out, 16'h0404);
        r_req = 0;
        cyc();

        // Both requesting from a fresh pointer
        Reset = 1; cyc(); Reset = 0;
        r_req = 1; r_x = 100; r_y = 3; r_color = 4'h2;
        b_req = 1; b_x = 0;   b_y = 0; b_color = 4'h6;
        order = '0; nwe = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            order = {order[2:0], obs_b};
            if (WE === 1'b1) nwe++;
        end
`ifdef FIXED_PRIORITY_EN
        check("tie_order", order, 4'b0000);
`else
        check("tie_order", order, 4'b0101);
`endif
        check("tie_we_count", nwe, 4);
        r_req = 0; b_req = 0;
        cyc();

        // Range boundaries
        r_req = 1; r_x = 640; r_y = 5;
        cyc();
        check("oobx_drop", drop, 1);
        check("oobx_we", WE, 0);
        r_x = 639; r_y = 10'(V_RES);
        cyc();
        check("ooby_drop", drop, 1);
        r_x = 639; r_y = 10'(V_RES - 1);
        cyc();
        check("corner_addr", write_address, WORDS - 1);

        // A write in flight completes as a clear starts; blue waits for IDLE
        r_x = 2; r_y = 1; r_color = 4'h9;
        cyc();
        r_req = 0;
        b_req = 1; b_x = 4; b_y = 4; b_color = 4'h5;
        clear_start = 1;
        cyc();
        clear_start = 0;
        done_seen = 0; nwe = 0; back = -1; i_done = -1;
        for (int i = 0; i < WORDS + 20; i++) begin
            cyc();
            if (obs_b) begin back = i; break; end
            if (obs_done) i_done = i;
            if (WE === 1'b1) nwe++;
        end
        check("clr_we_count", nwe, WORDS);
        check("clr_done_count", done_seen, 1);
        check("clr_back_after_done", (back > i_done) && (i_done >= 0), 1);
        b_req = 0;
        cyc();

        // Reset aborts a clear at word 1000
        clear_start = 1; cyc(); clear_start = 0;
        repeat (1000) cyc();
        Reset = 1;
        cyc();
        check("rst_mid_we", WE, 0);
        check("rst_mid_busy", clear_busy, 0);
        Reset = 0;
        done_seen = 0;
        repeat (5) cyc();
        check("rst_no_done", done_seen, 0);

        // Restart at word 500
        clear_start = 1; cyc(); clear_start = 0;
        repeat (500) cyc();
        clear_start = 1; cyc(); clear_start = 0;
        done_seen = 0;
        cyc();
        check("restart_addr", write_address, 0);
        nwe = (WE === 1'b1) ? 1 : 0;
        for (int i = 0; i < WORDS + 10; i++) begin
            cyc();
            if (obs_done) break;
            if (WE === 1'b1) nwe++;
        end
        check("restart_we_count", nwe, WORDS);
        check("restart_done_count", done_seen, 1);
        cyc();

        // Random bike traffic; each requester holds until acked
        for (int i = 0; i < 400; i++) begin
            if (!r_req && $urandom_range(0, 3) != 0) begin
                r_req = 1; r_x = 10'($urandom_range(0, 700));
                r_y = 10'($urandom_range(0, V_RES + 4)); r_color = 4'($urandom);
            end
            if (!b_req && $urandom_range(0, 3) != 0) begin
                b_req = 1; b_x = 10'($urandom_range(0, 700));
                b_y = 10'($urandom_range(0, V_RES + 4)); b_color = 4'($urandom);
            end
            cyc();
            if (g_r) r_req = 0;
            if (g_b) b_req = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
